// File: rtl/mem_ctrl_pkg.sv
// Shared types for the mclk-side memory controller: NoC packet layout,
// packet types, controller FSM states and request address slicing helpers.
// Imported by mem_ctrl_pipelined and its testbench.
package mem_ctrl_pkg;

  localparam int NOC_AW  = 8;    // stop address width
  localparam int NOC_PW  = 4;    // stop port width
  localparam int PKT_IDW = 8;    // transaction id width
  localparam int PKT_DW  = 128;  // packet payload width

  typedef enum logic [3:0] {
    PT_NONE                   = 4'd0,
    memory_read_request       = 4'd1,
    memory_write_request      = 4'd2,
    memory_read_reply         = 4'd3,
    memory_write_reply        = 4'd4,
    memory_write_line_request = 4'd5
  } pt_e;

  typedef struct packed {
    pt_e                pt;
    logic [PKT_IDW-1:0] id;
    logic [NOC_AW-1:0]  dst_addr;
    logic [NOC_PW-1:0]  dst_prt;
    logic [NOC_AW-1:0]  src_addr;
    logic [NOC_PW-1:0]  src_prt;
    logic [PKT_DW-1:0]  dat;
  } pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WR,
    ST_REPLY
  } state_e;

  // Byte address -> line index (caller truncates to the memory address width).
  function automatic logic [31:0] line_index(input logic [31:0] addr, input int line_bytes_log2);
    return addr >> line_bytes_log2;
  endfunction

  // Byte address -> word offset within its line.
  function automatic logic [31:0] word_offset(input logic [31:0] addr, input int line_bytes_log2,
                                              input int word_bytes_log2);
    logic [31:0] mask;
    mask = (32'd1 << (line_bytes_log2 - word_bytes_log2)) - 32'd1;
    return (addr >> word_bytes_log2) & mask;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with full/empty flags; read data is the head entry (show-ahead).
// Ports: i_clk/i_rst_n, i_push/i_wdat (ignored when full), i_pop (ignored when empty),
//        o_rdat head entry, o_full, o_empty. Pointers wrap at DEPTH.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdat  = r_mem[r_rp];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + AW'(1);
      if (w_pop)  r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_wdat;
  end

endmodule

// File: rtl/mem_ctrl_pipelined.sv
// Memory controller between a NoC stop port and a synchronous SRAM: buffers requests in a FIFO,
// services them in order (line read, word read-modify-write, full-line write), one reply each.
// Ports: mclk/rst (async active-low), req_* / rpl_* valid-ready packet channels, port_address/
// port_number (reply source), mem_* SRAM interface, busy, err_cnt (dropped packets, saturating).
module mem_ctrl_pipelined
  import mem_ctrl_pkg::*;
#(
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 32,
  parameter int MEM_AW    = 24,
  parameter int REQ_DEPTH = 4,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  pkt_t              req_pkt,
  output logic              rpl_valid,
  input  logic              rpl_ready,
  output pkt_t              rpl_pkt,
  input  logic [NOC_AW-1:0] port_address,
  input  logic [NOC_PW-1:0] port_number,
  output logic [MEM_AW-1:0] mem_addr_sel,
  output logic [LINE_W-1:0] mem_wdat,
  input  logic [LINE_W-1:0] mem_rdat,
  output logic              mem_en,
  output logic              mem_re,
  output logic              mem_we,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int PKT_W   = $bits(pkt_t);
  localparam int LB_LOG2 = $clog2(LINE_W / 8);
  localparam int WB_LOG2 = $clog2(WORD_W / 8);
  localparam int CNT_W   = 16;
  // r_cnt counts cycles already spent in the current state. RD_ISSUE is one
  // en&re cycle, so RD_WAIT covers the remaining RD_LAT-1 of them.
  localparam logic [CNT_W-1:0] RD_WAIT_LAST = CNT_W'(RD_LAT - 2);
  localparam logic [CNT_W-1:0] WR_LAST      = CNT_W'(WR_LAT - 1);

  state_e            r_state;
  state_e            w_next;
  pkt_t              r_req;
  pkt_t              r_rpl;
  logic [LINE_W-1:0] r_line;
  logic [7:0]        r_err_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_en;   // holds req_ready low until the first clock after reset

  logic [PKT_W-1:0]  w_fifo_rdat;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_is_read;
  logic              w_is_wwr;
  logic              w_is_lwr;
  logic              w_rd_done;
  logic              w_wr_done;
  logic [31:0]       w_line_idx;
  logic [31:0]       w_word;
  logic [31:0]       w_wbase;
  logic [LINE_W-1:0] w_wmask;
  logic [LINE_W-1:0] w_wdata;
  logic              w_unused;

  mem_req_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .i_clk   (mclk),
    .i_rst_n (rst),
    .i_push  (req_valid && req_ready),
    .i_wdat  (req_pkt),
    .i_pop   (w_pop),
    .o_rdat  (w_fifo_rdat),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_is_read  = (r_req.pt == memory_read_request);
  assign w_is_wwr   = (r_req.pt == memory_write_request);
  assign w_is_lwr   = (r_req.pt == memory_write_line_request);
  assign w_line_idx = line_index(r_req.dat[31:0], LB_LOG2);
  assign w_word     = word_offset(r_req.dat[31:0], LB_LOG2, WB_LOG2);
  assign w_wbase    = w_word * 32'(WORD_W);
  assign w_wmask    = LINE_W'({WORD_W{1'b1}}) << w_wbase;
  assign w_wdata    = LINE_W'(r_req.dat[32 +: WORD_W]) << w_wbase;
  assign w_rd_done  = ((r_state == ST_RD_ISSUE) && (RD_LAT == 1)) ||
                      ((r_state == ST_RD_WAIT) && (r_cnt == RD_WAIT_LAST));
  assign w_wr_done  = (r_state == ST_WR) && (r_cnt == WR_LAST);
  // Reply routing never looks at the request's own destination.
  assign w_unused   = ^{r_req.dst_addr, r_req.dst_prt, w_line_idx[31:MEM_AW]};

  assign mem_addr_sel = w_line_idx[MEM_AW-1:0];
  assign mem_wdat     = r_line;
  assign rpl_pkt      = r_rpl;
  assign err_cnt      = r_err_cnt;
  assign req_ready    = r_out_en && !w_full;
  assign busy         = (r_state != ST_IDLE) || !w_empty;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    mem_en    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    rpl_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_read || w_is_wwr) w_next = ST_RD_ISSUE;
        else if (w_is_lwr)         w_next = ST_WR;
        else                       w_next = ST_IDLE;
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        mem_en = 1'b1;
        mem_re = 1'b1;
        if (w_rd_done)                 w_next = w_is_read ? ST_REPLY : ST_MERGE;
        else if (r_state == ST_RD_ISSUE) w_next = ST_RD_WAIT;
      end
      ST_MERGE: w_next = ST_WR;
      ST_WR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (w_wr_done) w_next = ST_REPLY;
      end
      ST_REPLY: begin
        rpl_valid = 1'b1;
        if (rpl_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_req     <= '0;
      r_rpl     <= '0;
      r_line    <= '0;
      r_err_cnt <= '0;
      r_cnt     <= '0;
      r_out_en  <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      r_cnt    <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);

      if (w_pop) r_req <= w_fifo_rdat;

      if ((r_state == ST_DECODE) && w_is_lwr)  r_line <= r_req.dat[LINE_W-1:0];
      else if (w_rd_done)                      r_line <= mem_rdat;
      else if (r_state == ST_MERGE)            r_line <= (r_line & ~w_wmask) | w_wdata;

      if ((r_state == ST_DECODE) && !w_is_read && !w_is_wwr && !w_is_lwr && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;

      // Reply is captured once on entry so it stays stable while stalled.
      if ((w_next == ST_REPLY) && (r_state != ST_REPLY)) begin
        r_rpl.pt       <= w_is_read ? memory_read_reply : memory_write_reply;
        r_rpl.id       <= r_req.id;
        r_rpl.dst_addr <= r_req.src_addr;
        r_rpl.dst_prt  <= r_req.src_prt;
        r_rpl.src_addr <= port_address;
        r_rpl.src_prt  <= port_number;
        r_rpl.dat      <= w_is_read ? PKT_DW'(mem_rdat) : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_pipelined.sv
// Scoreboard testbench for mem_ctrl_pipelined: SRAM model, expected-reply and expected-write queues,
// reset, latency, RMW, FIFO-full, drop/saturation, reset-abort and random backpressure scenarios.
// Ports: none (top-level bench).
module tb_mem_ctrl_pipelined;
  import mem_ctrl_pkg::*;

  localparam int LINE_W = 128, WORD_W = 32, MEM_AW = 24, REQ_DEPTH = 4, RD_LAT = 2, WR_LAT = 1;
  localparam logic [NOC_AW-1:0] MY_ADDR = 8'h5A;
  localparam logic [NOC_PW-1:0] MY_PRT  = 4'h3;

  typedef struct { logic [MEM_AW-1:0] a; logic [LINE_W-1:0] d; } wr_t;

  logic mclk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, rpl_valid, rpl_ready = 1'b1;
  pkt_t req_pkt = '0, rpl_pkt;
  logic [MEM_AW-1:0] mem_addr_sel;
  logic [LINE_W-1:0] mem_wdat, mem_rdat = '0;
  logic mem_en, mem_re, mem_we, busy;
  logic [7:0] err_cnt;

  int checks = 0, failures = 0;
  pkt_t exp_q[$];
  wr_t  wr_q[$];
  logic [LINE_W-1:0] sim_mem [64];
  logic [LINE_W-1:0] ref_mem [64];

  mem_ctrl_pipelined #(
    .LINE_W(LINE_W), .WORD_W(WORD_W), .MEM_AW(MEM_AW),
    .REQ_DEPTH(REQ_DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .mclk(mclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pkt(req_pkt),
    .rpl_valid(rpl_valid), .rpl_ready(rpl_ready), .rpl_pkt(rpl_pkt),
    .port_address(MY_ADDR), .port_number(MY_PRT), .mem_addr_sel(mem_addr_sel),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat), .mem_en(mem_en), .mem_re(mem_re),
    .mem_we(mem_we), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM model: one register stage, so data is valid in the cycle after en&re
  // and is captured by the controller at the end of its second en&re cycle.
  always @(posedge mclk) begin
    if (mem_en && mem_re) mem_rdat <= sim_mem[mem_addr_sel[5:0]];
    if (mem_en && mem_we) sim_mem[mem_addr_sel[5:0]] <= mem_wdat;
  end

  // Reply scoreboard, reply stability, strobe exclusivity and write checks.
  logic prev_hold = 1'b0, prev_we = 1'b0;
  pkt_t prev_pkt = '0;
  always @(negedge mclk) begin
    if (!rst) begin
      prev_hold = 1'b0;
      prev_we   = 1'b0;
    end else begin
      if (prev_hold) chk("rpl_stable", 256'({rpl_valid, rpl_pkt}), 256'({1'b1, prev_pkt}));
      if (rpl_valid && rpl_ready) begin
        if (exp_q.size() == 0) chk("rpl_unexpected", 256'(rpl_pkt), 256'(0));
        else chk("rpl_pkt", 256'(rpl_pkt), 256'(exp_q.pop_front()));
      end
      if (mem_en) chk("re_we_excl", 256'(mem_re && mem_we), 256'(0));
      if (mem_en && mem_we && !prev_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 256'(mem_addr_sel), 256'(0));
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", 256'(mem_addr_sel), 256'(w.a));
          chk("wr_dat", 256'(mem_wdat), 256'(w.d));
        end
      end
      prev_hold = rpl_valid && !rpl_ready;
      prev_pkt  = rpl_pkt;
      prev_we   = mem_en && mem_we;
    end
  end

  function automatic pkt_t mk(input pt_e pt, input logic [7:0] id, input logic [31:0] addr,
                              input logic [127:0] payload);
    pkt_t p;
    p          = '0;
    p.pt       = pt;
    p.id       = id;
    p.dst_addr = MY_ADDR;
    p.dst_prt  = MY_PRT;
    p.src_addr = id ^ 8'hC3;
    p.src_prt  = id[3:0];
    p.dat      = payload;
    p.dat[31:0] = addr;
    return p;
  endfunction

  // Reference behaviour for an accepted request, applied in acceptance order.
  task automatic predict(input pkt_t p);
    pkt_t r;
    logic [31:0] line;
    int word;
    logic [LINE_W-1:0] nl;
    line = p.dat[31:0] >> 4;
    word = int'(p.dat[3:2]);
    r = '0;
    r.id = p.id; r.dst_addr = p.src_addr; r.dst_prt = p.src_prt;
    r.src_addr = MY_ADDR; r.src_prt = MY_PRT;
    case (p.pt)
      memory_read_request: begin
        r.pt = memory_read_reply; r.dat = ref_mem[line[5:0]]; exp_q.push_back(r);
      end
      memory_write_request, memory_write_line_request: begin
        nl = ref_mem[line[5:0]];
        if (p.pt == memory_write_request) nl[word*WORD_W +: WORD_W] = p.dat[63:32];
        else nl = p.dat;
        ref_mem[line[5:0]] = nl;
        wr_q.push_back('{line[MEM_AW-1:0], nl});
        r.pt = memory_write_reply; exp_q.push_back(r);
      end
      default: ;
    endcase
  endtask

  // Offer a packet; call #1 after a posedge. Returns #1 after the accepting edge.
  task automatic send(input pkt_t p, input int bound, input bit must, output bit acc);
    int n = 0;
    req_pkt = p; req_valid = 1'b1;
    while (!req_ready && n < bound) begin @(posedge mclk); #1; n++; end
    acc = req_ready;
    if (acc) begin @(posedge mclk); #1; end
    req_valid = 1'b0;
    if (must && !acc) chk("req_accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic send_pred(input pkt_t p);
    bit acc;
    send(p, 200, 1'b1, acc);
    if (acc) predict(p);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(posedge mclk); #1; n++; end
    chk("drain_timeout", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin : main
    bit acc, done;
    int n, re_at;
    logic [MEM_AW-1:0] re_addr;
    for (int i = 0; i < 64; i++) ref_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    ref_mem[1] = 128'h0123_4567_89AB_CDEF_CAFE_F00D_DEAD_BEEF;
    ref_mem[2] = {4{32'hAAAA_AAAA}};
    for (int i = 0; i < 64; i++) sim_mem[i] = ref_mem[i];

    // Reset state
    #2 rst = 1'b0;
    #3;
    chk("rst_ctl", 256'({rpl_valid, req_ready, mem_en, mem_re, mem_we, busy, err_cnt, mem_addr_sel}), 256'(0));
    chk("rst_wdat", 256'(mem_wdat), 256'(0));
    chk("rst_rpl", 256'(rpl_pkt), 256'(0));
    @(negedge mclk); @(negedge mclk); rst = 1'b1;
    @(posedge mclk); #1;

    // 1. Line read: mem_re at pop+2, rpl_valid at pop+2+RD_LAT (pop is the cycle after acceptance)
    send_pred(mk(memory_read_request, 8'h11, 32'h0000_0010, '0));
    n = 0; re_at = -1; re_addr = '0;
    while (!rpl_valid && n < 50) begin
      @(posedge mclk); #1; n++;
      if (mem_re && re_at < 0) begin re_at = n; re_addr = mem_addr_sel; end
    end
    chk("rd_re_latency", 256'(re_at), 256'(2));
    chk("rd_addr_sel", 256'(re_addr), 256'(1));
    chk("rd_rpl_latency", 256'(n), 256'(2 + RD_LAT));
    drain();

    // 2. Word write, read-modify-write onto 0xAAAA.. line
    send_pred(mk(memory_write_request, 8'h22, 32'h0000_0024, {64'h0, 32'h1234_5678, 32'h0}));
    drain();
    chk("rmw_line", 256'(sim_mem[2]), 256'(128'hAAAA_AAAA_AAAA_AAAA_1234_5678_AAAA_AAAA));

    // 4. Dropped packet followed by a read
    send_pred(mk(pt_e'(4'hF), 8'h44, 32'h0000_0030, '0));
    send_pred(mk(memory_read_request, 8'h45, 32'h0000_0020, '0));
    drain();
    chk("err_cnt_one", 256'(err_cnt), 256'(1));

    // 3. Stalled replies: one request sits in REPLY, REQ_DEPTH more fill the FIFO
    rpl_ready = 1'b0;
    for (int i = 0; i < REQ_DEPTH + 1; i++)
      send_pred(mk(memory_read_request, 8'(8'h30 + i), 32'(i * 16 + 16'h100), '0));
    chk("full_ready_low", 256'(req_ready), 256'(0));
    send(mk(memory_read_request, 8'h3F, 32'h0000_0200, '0), 10, 1'b0, acc);
    chk("full_refused", 256'(acc), 256'(0));
    rpl_ready = 1'b1;
    drain();

    // 6. Random traffic with random reply backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [31:0] a;
          int k;
          a = (32'($urandom_range(0, 63)) << 4) | (32'($urandom_range(0, 3)) << 2);
          k = $urandom_range(0, 2);
          if (k == 0)      send_pred(mk(memory_read_request, 8'(8'h60 + i), a, '0));
          else if (k == 1) send_pred(mk(memory_write_request, 8'(8'h60 + i), a, {64'h0, $urandom, 32'h0}));
          else send_pred(mk(memory_write_line_request, 8'(8'h60 + i), a, {$urandom, $urandom, $urandom, $urandom}));
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          @(posedge mclk); #1;
          rpl_ready = 1'($urandom_range(0, 1));
          if (done && exp_q.size() == 0) break;
        end
        rpl_ready = 1'b1;
      end
    join
    drain();

    // err_cnt saturation
    for (int i = 0; i < 260; i++)
      send_pred(mk((i % 2 == 0) ? pt_e'(4'hF) : memory_write_reply, 8'(i), 32'h0, '0));
    drain();
    chk("err_cnt_sat", 256'(err_cnt), 256'(255));

    // 5. Reset while writing: in-flight and queued requests are discarded
    send(mk(memory_write_request, 8'h90, 32'h0000_0094, {64'h0, 32'h5555_5555, 32'h0}), 200, 1'b1, acc);
    send(mk(memory_read_request, 8'h91, 32'h0000_0090, '0), 200, 1'b1, acc);
    n = 0;
    while (!mem_we && n < 50) begin @(posedge mclk); #1; n++; end
    chk("rst_reached_wr", 256'(mem_we), 256'(1));
    rst = 1'b0;
    #1;
    chk("rst_wr_ctl", 256'({rpl_valid, req_ready, mem_en, mem_re, mem_we, busy, err_cnt, mem_addr_sel}), 256'(0));
    chk("rst_wr_wdat", 256'(mem_wdat), 256'(0));
    @(negedge mclk); rst = 1'b1;
    @(posedge mclk); @(posedge mclk); #1;
    send_pred(mk(memory_read_request, 8'h92, 32'h0000_0098, '0));
    drain();

    chk("exp_q_empty", 256'(exp_q.size()), 256'(0));
    chk("wr_q_empty", 256'(wr_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
